// File: rtl/hist_eq_stream_core.sv
// Streaming histogram equaliser: maps pixels through a LUT, learns histograms on selected frames, rebuilds LUT between frames.
// Optional per-bin clip limit enabled by defining HE_CLIP_EN.
`timescale 1ns/1ps
module hist_eq_stream_core #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned HIST_W         = 17,
  parameter int unsigned RELEARN_PERIOD = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_gray,
  input  logic              i_end,
  output logic              o_in_ready,
  input  logic              i_relearn,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_gray_eq,
  output logic              o_end,
  input  logic              i_out_ready,
  output logic              o_done,
`ifdef HE_CLIP_EN
  input  logic [HIST_W-1:0] i_clip_limit,
`endif
  output logic              o_lut_valid
);

  localparam int unsigned BINS   = 1 << DATA_W;
  localparam int unsigned MAXV   = BINS - 1;
  localparam int unsigned ACC_W  = HIST_W + DATA_W;
  localparam int unsigned PROD_W = ACC_W + DATA_W;
  localparam int unsigned CNT_W  = $clog2(RELEARN_PERIOD + 1);

  typedef enum logic [1:0] {ST_STREAM, ST_BUILD_CDF, ST_BUILD_LUT} state_t;

  state_t              r_state;
  logic [HIST_W-1:0]   r_hist [BINS];
  logic [ACC_W-1:0]    r_cdf  [BINS];
  logic [DATA_W-1:0]   r_lut  [BINS];
  logic [CNT_W-1:0]    r_frame_cnt;
  logic                r_relearn_pend;
  logic                r_learn;
  logic                r_in_frame;
  logic [DATA_W-1:0]   r_idx;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_cdf_min;
  logic                r_cdf_min_found;
  logic [ACC_W-1:0]    r_total;
`ifdef HE_CLIP_EN
  logic [HIST_W-1:0]   r_clip_limit;
`endif

  logic                w_accept;
  logic                w_frame_start;
  logic                w_learn_now;
  logic [HIST_W-1:0]   w_hist_cur;
  logic [HIST_W-1:0]   w_contrib;
  logic [ACC_W-1:0]    w_acc_next;
  logic [ACC_W-1:0]    w_cdf_cur;
  logic [ACC_W-1:0]    w_diff;
  logic [ACC_W-1:0]    w_span;
  logic [PROD_W-1:0]   w_num;
  logic [PROD_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_lut_val;
  logic                w_unused_quot;

  assign o_in_ready    = (r_state == ST_STREAM) && (!o_valid || i_out_ready);
  assign w_accept      = i_valid && o_in_ready;
  assign w_frame_start = w_accept && !r_in_frame;
  // The first pixel of a frame must already see the learn decision made for that frame.
  assign w_learn_now   = w_frame_start
                       ? (!o_lut_valid || r_relearn_pend ||
                          (r_frame_cnt == CNT_W'(RELEARN_PERIOD - 1)))
                       : r_learn;

  assign w_hist_cur = r_hist[r_idx];
`ifdef HE_CLIP_EN
  assign w_contrib  = ((r_clip_limit != '0) && (w_hist_cur > r_clip_limit)) ? r_clip_limit : w_hist_cur;
`else
  assign w_contrib  = w_hist_cur;
`endif
  assign w_acc_next = r_acc + ACC_W'(w_contrib);

  // LUT entry for the bin currently being rebuilt
  assign w_cdf_cur     = r_cdf[r_idx];
  assign w_diff        = w_cdf_cur - r_cdf_min;
  assign w_span        = r_total - r_cdf_min;
  assign w_num         = PROD_W'(w_diff) * PROD_W'(MAXV);
  assign w_quot        = (w_span == '0) ? '0 : (w_num / PROD_W'(w_span));
  assign w_unused_quot = ^w_quot[PROD_W-1:DATA_W];

  always_comb begin
    w_lut_val = w_quot[DATA_W-1:0];
    if (r_total == r_cdf_min)
      w_lut_val = r_idx;
    else if (w_cdf_cur < r_cdf_min)
      w_lut_val = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state         <= ST_STREAM;
      o_valid         <= 1'b0;
      o_gray_eq       <= '0;
      o_end           <= 1'b0;
      o_done          <= 1'b0;
      o_lut_valid     <= 1'b0;
      r_frame_cnt     <= '0;
      r_relearn_pend  <= 1'b0;
      r_learn         <= 1'b0;
      r_in_frame      <= 1'b0;
      r_idx           <= '0;
      r_acc           <= '0;
      r_cdf_min       <= '0;
      r_cdf_min_found <= 1'b0;
      r_total         <= '0;
`ifdef HE_CLIP_EN
      r_clip_limit    <= '0;
`endif
      for (int b = 0; b < int'(BINS); b++) begin
        r_hist[b] <= '0;
        r_lut[b]  <= DATA_W'(b);
      end
    end else begin
      o_done <= 1'b0;

      if (i_relearn)
        r_relearn_pend <= 1'b1;
      else if (w_frame_start)
        r_relearn_pend <= 1'b0;

      if (w_accept) begin
        o_gray_eq <= r_lut[i_gray];
        o_end     <= i_end;
        o_valid   <= 1'b1;
      end else if (o_valid && i_out_ready) begin
        o_valid <= 1'b0;
      end

      case (r_state)
        ST_STREAM: begin
          if (w_accept) begin
            r_learn    <= w_learn_now;
            r_in_frame <= !i_end;
            if (w_learn_now && (r_hist[i_gray] != '1))
              r_hist[i_gray] <= r_hist[i_gray] + HIST_W'(1);
            if (i_end) begin
              if (w_learn_now) begin
                r_state         <= ST_BUILD_CDF;
                r_idx           <= '0;
                r_acc           <= '0;
                r_cdf_min_found <= 1'b0;
`ifdef HE_CLIP_EN
                r_clip_limit    <= i_clip_limit;
`endif
              end else begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
              end
            end
          end
        end

        ST_BUILD_CDF: begin
          r_acc        <= w_acc_next;
          r_cdf[r_idx] <= w_acc_next;
          if (!r_cdf_min_found && (w_acc_next != '0)) begin
            r_cdf_min       <= w_acc_next;
            r_cdf_min_found <= 1'b1;
          end
          r_idx <= r_idx + DATA_W'(1);
          if (r_idx == DATA_W'(MAXV)) begin
            r_total <= w_acc_next;
            r_state <= ST_BUILD_LUT;
          end
        end

        ST_BUILD_LUT: begin
          r_lut[r_idx]  <= w_lut_val;
          r_hist[r_idx] <= '0;
          r_idx         <= r_idx + DATA_W'(1);
          if (r_idx == DATA_W'(MAXV)) begin
            o_lut_valid <= 1'b1;
            r_frame_cnt <= '0;
            r_learn     <= 1'b0;
            o_done      <= 1'b1;
            r_state     <= ST_STREAM;
          end
        end

        default: r_state <= ST_STREAM;
      endcase
    end
  end

endmodule

// File: tb/tb_hist_eq_stream_core.sv
// Scoreboard bench for hist_eq_stream_core (DATA_W=8, RELEARN_PERIOD=3); clip cases run when HE_CLIP_EN is defined.
`timescale 1ns/1ps
module tb_hist_eq_stream_core;

  localparam int unsigned DW = 8;
  localparam int unsigned HW = 17;
  localparam int unsigned RP = 3;
  localparam int BUILD_CYC   = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic [DW-1:0] i_gray;
  logic          i_end;
  logic          o_in_ready;
  logic          i_relearn;
  logic          o_valid;
  logic [DW-1:0] o_gray_eq;
  logic          o_end;
  logic          i_out_ready;
  logic          o_done;
  logic          o_lut_valid;
`ifdef HE_CLIP_EN
  logic [HW-1:0] i_clip_limit;
`endif

  always #5 clk = ~clk;

  hist_eq_stream_core #(.DATA_W(DW), .HIST_W(HW), .RELEARN_PERIOD(RP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_gray(i_gray), .i_end(i_end),
    .o_in_ready(o_in_ready), .i_relearn(i_relearn), .o_valid(o_valid), .o_gray_eq(o_gray_eq),
    .o_end(o_end), .i_out_ready(i_out_ready), .o_done(o_done),
`ifdef HE_CLIP_EN
    .i_clip_limit(i_clip_limit),
`endif
    .o_lut_valid(o_lut_valid)
  );

  typedef struct packed { logic [DW-1:0] g; logic e; } exp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int end_cyc = 0;
  int done_cnt = 0;
  exp_t sb[$];
  exp_t m_e;
  logic [DW-1:0] q_px[$];
  logic [DW-1:0] q_ex[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop and compare every transferred output; time every rebuild.
  always @(negedge clk) begin
    if (rst_n && o_done) begin
      done_cnt++;
      chk("done_latency", cyc - end_cyc, BUILD_CYC);
    end
    if (rst_n && o_valid && i_out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %0d expected none", o_gray_eq);
      end else begin
        m_e = sb.pop_front();
        chk("out_gray", o_gray_eq, m_e.g);
        chk("out_end", o_end, m_e.e);
      end
    end
  end

  task automatic add(input logic [DW-1:0] px, input logic [DW-1:0] ex, input int n);
    repeat (n) begin
      q_px.push_back(px);
      q_ex.push_back(ex);
    end
  endtask

  task automatic send_frame();
    logic [DW-1:0] px, ex;
    logic last, acc;
    while (q_px.size() > 0) begin
      px = q_px.pop_front();
      ex = q_ex.pop_front();
      last = (q_px.size() == 0);
      i_valid = 1'b1;
      i_gray  = px;
      i_end   = last;
      acc = 1'b0;
      for (int t = 0; t < 2000 && !acc; t++) begin
        @(negedge clk);
        if (o_in_ready) begin
          acc = 1'b1;
          sb.push_back('{g: ex, e: last});
        end
        @(posedge clk);
        #1;
      end
      chk("accept_in_time", acc, 1);
      if (last) end_cyc = cyc;
    end
    i_valid = 1'b0;
    i_end   = 1'b0;
  endtask

  task automatic idle(input int exp_done);
    repeat (600) @(posedge clk);
    #1;
    chk("done_count", done_cnt, exp_done);
  endtask

  task automatic stall();
    logic [DW-1:0] hg;
    logic he;
    repeat (5) @(posedge clk);
    #1 i_out_ready = 1'b0;
    @(negedge clk);
    chk("stall_in_ready", o_in_ready, 0);
    chk("stall_valid", o_valid, 1);
    hg = o_gray_eq;
    he = o_end;
    repeat (4) begin
      @(negedge clk);
      chk("stall_in_ready", o_in_ready, 0);
      chk("stall_valid_held", o_valid, 1);
      chk("stall_gray_held", o_gray_eq, hg);
      chk("stall_end_held", o_end, he);
    end
    @(posedge clk);
    #1 i_out_ready = 1'b1;
  endtask

  task automatic pulse_relearn(input int delay);
    repeat (delay) @(posedge clk);
    #1 i_relearn = 1'b1;
    @(posedge clk);
    #1 i_relearn = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_gray = '0; i_end = 1'b0;
    i_relearn = 1'b0; i_out_ready = 1'b1;
`ifdef HE_CLIP_EN
    i_clip_limit = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_gray_eq", o_gray_eq, 0);
    chk("rst_o_end", o_end, 0);
    chk("rst_o_done", o_done, 0);
    chk("rst_o_lut_valid", o_lut_valid, 0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", o_in_ready, 1);

    // Frame 1: learn through identity LUT
    add(50, 50, 8); add(150, 150, 8);
    send_frame();
    @(negedge clk) chk("build_in_ready", o_in_ready, 0);
    idle(1);
    chk("lut_valid_f1", o_lut_valid, 1);

    // Frame 2: new LUT, downstream stall mid-frame
    add(50, 0, 8); add(150, 255, 8);
    fork
      send_frame();
      stall();
    join
    idle(1);

    // Frame 3: still no learn
    add(50, 0, 1); add(100, 0, 1); add(150, 255, 1); add(200, 255, 1);
    send_frame();
    idle(1);

    // Frame 4: periodic learn
    add(100, 0, 2); add(150, 255, 2); add(200, 255, 4);
    send_frame();
    idle(2);

    // Frame 5: uses frame-4 LUT, relearn pulsed mid-frame
    add(100, 0, 1); add(150, 85, 1); add(200, 255, 1); add(50, 0, 1);
    fork
      send_frame();
      pulse_relearn(2);
    join
    idle(2);

    // Frame 6: forced learn
    add(150, 85, 3); add(200, 255, 1);
    send_frame();
    idle(3);

    // Frames 7, 8: frame count restarted, no learn
    add(150, 0, 1); add(200, 255, 1);
    send_frame();
    idle(3);
    add(175, 0, 1); add(200, 255, 1);
    send_frame();
    idle(3);

    // Frame 9: periodic learn aborted by reset at LUT bin 100
    add(30, 0, 4);
    send_frame();
    repeat (356) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("abort_lut_valid", o_lut_valid, 0);
    chk("abort_o_valid", o_valid, 0);
    chk("abort_o_done", o_done, 0);
    idle(3);

    // Frame 10: identity mapping again, learns
    add(77, 77, 1); add(200, 200, 1);
    send_frame();
    idle(4);
    chk("lut_valid_f10", o_lut_valid, 1);

`ifdef HE_CLIP_EN
    i_clip_limit = '0;
    pulse_relearn(1);
    add(10, 0, 2); add(20, 0, 12); add(30, 0, 2);
    send_frame();
    idle(5);
    add(10, 0, 2); add(20, 218, 12); add(30, 255, 2);
    send_frame();
    idle(5);
    i_clip_limit = HW'(4);
    pulse_relearn(1);
    add(10, 0, 2); add(20, 218, 12); add(30, 255, 2);
    send_frame();
    idle(6);
    add(10, 0, 2); add(20, 170, 12); add(30, 255, 2);
    send_frame();
    idle(6);
`endif

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
